// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operation codes,
// FSM states and the iteration counter width.
package mult_div_unit_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_CNT_W = $clog2(MDU_WIDTH);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Bundle of the request, move-to and result signals between the datapath
// and the multiply/divide unit.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] OperandA;
    logic [WIDTH-1:0] OperandB;
    logic             HiWrite;
    logic             LoWrite;
    logic [WIDTH-1:0] WriteData;
    logic             Busy;
    logic             Done;
    logic             DivZero;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output Start, Op, OperandA, OperandB, HiWrite, LoWrite, WriteData,
        input  Busy, Done, DivZero, Hi, Lo
    );

    modport slave (
        input  Start, Op, OperandA, OperandB, HiWrite, LoWrite, WriteData,
        output Busy, Done, DivZero, Hi, Lo
    );
endinterface

// File: rtl/mult_div_unit_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide on
// unsigned magnitudes. The 2*WIDTH accumulator holds {hi, lo}; for divide
// hi is the partial remainder and lo collects quotient bits.
module mult_div_unit_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     rem_sh_s;
    logic [WIDTH:0]     diff_s;

    // Next accumulator: load magnitudes, or perform one multiply/divide step.
    always_comb begin
        mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        rem_sh_s  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff_s    = rem_sh_s - {1'b0, b_q};
        acc_d     = acc_q;
        b_d       = b_q;
        if (load_i) begin
            acc_d = {{WIDTH{1'b0}}, a_i};
            b_d   = b_i;
        end else if (step_i) begin
            if (is_div_i) begin
                // A borrow out of the trial subtraction means the divisor did not fit.
                if (diff_s[WIDTH]) begin
                    acc_d = {rem_sh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end
            end else begin
                acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator and latched second operand registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= {(2*WIDTH){1'b0}};
            b_q   <= {WIDTH{1'b0}};
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
        end
    end

    assign hi_o = acc_q[2*WIDTH-1:WIDTH];
    assign lo_o = acc_q[WIDTH-1:0];
endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: FSM, sign handling and the
// architectural HI/LO registers around the one-bit-per-cycle core.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic           Clk,
    input  logic           Reset,
    mult_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    mdu_state_e       state_q;
    mdu_op_e          op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_prod_q, neg_rem_q, b_zero_q;
    logic [WIDTH-1:0] a_raw_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             busy_q, done_q, div_zero_q;

    mdu_op_e            op_in_s;
    logic               accept_s, sign_a_s, sign_b_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s;
    logic [WIDTH-1:0]   core_hi_s, core_lo_s;
    logic [2*WIDTH-1:0] prod_s, prod_neg_s;
    logic [WIDTH-1:0]   hi_res_s, lo_res_s;

    // Operand magnitudes and sign flags for a request presented in IDLE.
    always_comb begin
        op_in_s  = mdu_op_e'(bus.Op);
        accept_s = (state_q == S_IDLE) && bus.Start;
        sign_a_s = op_is_signed(op_in_s) & bus.OperandA[WIDTH-1];
        sign_b_s = op_is_signed(op_in_s) & bus.OperandB[WIDTH-1];
        a_mag_s  = sign_a_s ? (~bus.OperandA + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.OperandA;
        b_mag_s  = sign_b_s ? (~bus.OperandB + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.OperandB;
    end

    mult_div_unit_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk_i    (Clk),
        .rst_i    (Reset),
        .load_i   (accept_s),
        .step_i   (state_q == S_RUN),
        .is_div_i (op_is_div(op_q)),
        .a_i      (a_mag_s),
        .b_i      (b_mag_s),
        .hi_o     (core_hi_s),
        .lo_o     (core_lo_s)
    );

    // Final HI/LO values: sign correction, or the fixed divide-by-zero pattern.
    always_comb begin
        prod_s     = {core_hi_s, core_lo_s};
        prod_neg_s = ~prod_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
        hi_res_s   = core_hi_s;
        lo_res_s   = core_lo_s;
        if (op_is_div(op_q)) begin
            if (b_zero_q) begin
                hi_res_s = a_raw_q;
                lo_res_s = {WIDTH{1'b1}};
            end else begin
                hi_res_s = neg_rem_q  ? (~core_hi_s + {{(WIDTH-1){1'b0}}, 1'b1}) : core_hi_s;
                lo_res_s = neg_prod_q ? (~core_lo_s + {{(WIDTH-1){1'b0}}, 1'b1}) : core_lo_s;
            end
        end else if (neg_prod_q) begin
            hi_res_s = prod_neg_s[2*WIDTH-1:WIDTH];
            lo_res_s = prod_neg_s[WIDTH-1:0];
        end else begin
            hi_res_s = prod_s[2*WIDTH-1:WIDTH];
            lo_res_s = prod_s[WIDTH-1:0];
        end
    end

    // Control FSM with registered status outputs and the HI/LO registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            op_q       <= OP_MULT;
            cnt_q      <= {CNT_W{1'b0}};
            neg_prod_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            b_zero_q   <= 1'b0;
            a_raw_q    <= {WIDTH{1'b0}};
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.Start) begin
                        op_q       <= op_in_s;
                        neg_prod_q <= sign_a_s ^ sign_b_s;
                        neg_rem_q  <= sign_a_s;
                        b_zero_q   <= (bus.OperandB == {WIDTH{1'b0}});
                        a_raw_q    <= bus.OperandA;
                        div_zero_q <= 1'b0;
                        busy_q     <= 1'b1;
                        cnt_q      <= {CNT_W{1'b0}};
                        state_q    <= S_RUN;
                    end else begin
                        if (bus.HiWrite) begin
                            hi_q <= bus.WriteData;
                        end
                        if (bus.LoWrite) begin
                            lo_q <= bus.WriteData;
                        end
                    end
                end
                S_RUN: begin
                    done_q <= 1'b0;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi_q       <= hi_res_s;
                    lo_q       <= lo_res_s;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    div_zero_q <= op_is_div(op_q) & b_zero_q;
                    cnt_q      <= {CNT_W{1'b0}};
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;
    assign bus.DivZero = div_zero_q;
    assign bus.Hi      = hi_q;
    assign bus.Lo      = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: expected HI/LO/DivZero come from a
// behavioural arithmetic model and are queued at launch, then popped on Done.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] arch_hi, arch_lo;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(32)) bus();

    mult_div_unit #(.WIDTH(32)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        logic signed [63:0] sa, sb, sr;
        logic [63:0]        ua, ub, ur;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        dz = 1'b0;
        hi = 32'h0;
        lo = 32'h0;
        case (op)
            2'b00: begin sr = sa * sb; hi = sr[63:32]; lo = sr[31:0]; end
            2'b01: begin ur = ua * ub; hi = ur[63:32]; lo = ur[31:0]; end
            default: begin
                if (b == 32'h0) begin
                    hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1;
                end else if (op == 2'b10) begin
                    sr = sa / sb; lo = sr[31:0];
                    sr = sa % sb; hi = sr[31:0];
                end else begin
                    ur = ua / ub; lo = ur[31:0];
                    ur = ua % ub; hi = ur[31:0];
                end
            end
        endcase
    endfunction

    // Present a request at a falling edge; it is sampled at the next rising edge.
    task automatic start_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input bit push, input bit with_hiw);
        exp_t e;
        logic [31:0] h, l;
        logic d;
        model(op, a, b, h, l, d);
        bus.Start = 1'b1; bus.Op = op; bus.OperandA = a; bus.OperandB = b;
        if (with_hiw) begin
            bus.HiWrite = 1'b1; bus.WriteData = 32'h5555_5555;
        end
        if (push) begin
            e.hi = h; e.lo = l; e.dz = d; e.tag = tag;
            sb_q.push_back(e);
        end
        @(negedge clk);
        bus.Start = 1'b0; bus.HiWrite = 1'b0;
        chk({tag, "_busy_acc"}, {31'h0, bus.Busy}, 32'h1);
        chk({tag, "_dz_clr"}, {31'h0, bus.DivZero}, 32'h0);
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int n;
        bit stable;
        exp_t e;
        n = 0;
        stable = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (bus.Done !== 1'b1 && (bus.Hi !== arch_hi || bus.Lo !== arch_lo || bus.Busy !== 1'b1))
                stable = 1'b0;
        end while (bus.Done !== 1'b1 && n < 60);
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_stable"}, {31'h0, stable}, 32'h1);
        chk({tag, "_busy_done"}, {31'h0, bus.Busy}, 32'h0);
        if (sb_q.size() == 0) begin
            checks++; failures++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk({e.tag, "_hi"}, bus.Hi, e.hi);
            chk({e.tag, "_lo"}, bus.Lo, e.lo);
            chk({e.tag, "_dz"}, {31'h0, bus.DivZero}, {31'h0, e.dz});
            arch_hi = e.hi;
            arch_lo = e.lo;
        end
    endtask

    initial begin
        int dones;
        logic [1:0] rop;
        logic [31:0] ra, rb;
        rst = 1'b1;
        bus.Start = 1'b0; bus.Op = 2'b00; bus.OperandA = 32'h0; bus.OperandB = 32'h0;
        bus.HiWrite = 1'b0; bus.LoWrite = 1'b0; bus.WriteData = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, bus.Busy}, 32'h0);
        chk("rst_done", {31'h0, bus.Done}, 32'h0);
        chk("rst_dz", {31'h0, bus.DivZero}, 32'h0);
        chk("rst_hi", bus.Hi, 32'h0);
        chk("rst_lo", bus.Lo, 32'h0);
        rst = 1'b0;
        arch_hi = 32'h0; arch_lo = 32'h0;

        // MTHI while idle, then MTHI+MTLO together
        bus.HiWrite = 1'b1; bus.WriteData = 32'h0000_1234;
        @(negedge clk);
        bus.HiWrite = 1'b0;
        arch_hi = 32'h0000_1234;
        chk("mthi_hi", bus.Hi, arch_hi);
        chk("mthi_lo", bus.Lo, arch_lo);
        bus.HiWrite = 1'b1; bus.LoWrite = 1'b1; bus.WriteData = 32'h0000_ABCD;
        @(negedge clk);
        bus.HiWrite = 1'b0; bus.LoWrite = 1'b0;
        arch_hi = 32'h0000_ABCD; arch_lo = 32'h0000_ABCD;
        chk("mtboth_hi", bus.Hi, arch_hi);
        chk("mtboth_lo", bus.Lo, arch_lo);

        // Arithmetic, launched back-to-back on each Done cycle
        start_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        wait_done("multu_max", 33);
        chk("multu_max_hi_k", bus.Hi, 32'hFFFF_FFFE);
        chk("multu_max_lo_k", bus.Lo, 32'h0000_0001);
        start_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 1'b0);
        wait_done("mult_neg", 33);
        start_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b0);
        wait_done("div_neg", 33);
        start_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b1, 1'b0);
        wait_done("divu_100_7", 33);
        start_op("divu_zero", OP_DIVU, 32'd100, 32'd0, 1'b1, 1'b0);
        wait_done("divu_zero", 33);
        start_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        wait_done("div_ovf", 33);
        start_op("div_zero_s", OP_DIV, 32'hFFFF_FFF9, 32'd0, 1'b1, 1'b0);
        wait_done("div_zero_s", 33);
        @(negedge clk);
        start_op("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        wait_done("mult_min", 33);
        start_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
        wait_done("div_7_m2", 33);

        // MTLO during Busy is ignored
        start_op("mtlo_busy", OP_MULTU, 32'd3, 32'd4, 1'b1, 1'b0);
        bus.LoWrite = 1'b1; bus.WriteData = 32'h0000_DEAD;
        @(negedge clk);
        bus.LoWrite = 1'b0;
        chk("mtlo_busy_lo", bus.Lo, arch_lo);
        wait_done("mtlo_busy", 32);

        // MTHI coincident with Start is ignored
        start_op("hiw_start", OP_DIVU, 32'd50, 32'd6, 1'b1, 1'b1);
        chk("hiw_start_hi", bus.Hi, arch_hi);
        wait_done("hiw_start", 33);

        // Start while Busy has no effect on the running operation
        start_op("start_busy", OP_MULTU, 32'd5, 32'd5, 1'b1, 1'b0);
        repeat (9) @(negedge clk);
        bus.Start = 1'b1; bus.Op = OP_DIVU; bus.OperandA = 32'd9; bus.OperandB = 32'd3;
        @(negedge clk);
        bus.Start = 1'b0;
        wait_done("start_busy", 23);

        // Random operations
        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 2) ? 32'h0 : ((i == 3) ? 32'($urandom_range(1, 100)) : $urandom);
            start_op($sformatf("rnd%0d", i), rop, ra, rb, 1'b1, 1'b0);
            wait_done($sformatf("rnd%0d", i), 33);
        end

        // Reset mid-operation discards the operation
        start_op("abort", OP_MULTU, 32'd5, 32'd5, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        bus.Start = 1'b1; bus.Op = OP_DIVU; bus.OperandA = 32'd9; bus.OperandB = 32'd3;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        arch_hi = 32'h0; arch_lo = 32'h0;
        chk("abort_busy", {31'h0, bus.Busy}, 32'h0);
        chk("abort_hi", bus.Hi, 32'h0);
        chk("abort_lo", bus.Lo, 32'h0);
        dones = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (bus.Done === 1'b1) dones++;
        end
        chk("abort_no_done", dones, 32'd0);
        chk("abort_sb_empty", sb_q.size(), 32'd0);

        // Recovery after reset
        start_op("after_rst", OP_DIVU, 32'd9, 32'd3, 1'b1, 1'b0);
        wait_done("after_rst", 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
